// File: rtl/writeback_retire.sv
// writeback_retire: two-lane writeback retire with in-order pending-write queue and WAW-safe scoreboard clear
module writeback_retire #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb1_valid,
  input  logic        wb1_wen,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  input  logic        wb2_valid,
  input  logic        wb2_wen,
  input  logic [4:0]  wb2_rd,
  input  logic [31:0] wb2_data,
  output logic        wb_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        sb_clr,
  output logic [4:0]  sb_clr_idx,
  output logic [15:0] retire_count,
  output logic        q_full,
  output logic        q_empty
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] READY_MAX = (AW+1)'(QDEPTH - 2);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(QDEPTH);
  logic [4:0]    r_rd   [QDEPTH];
  logic [31:0]   r_data [QDEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_occ;
  logic          r_we, r_clr;
  logic [4:0]    r_waddr, r_clr_idx;
  logic [31:0]   r_wdata;
  logic [15:0]   r_cnt;
  logic          w_push1, w_push2, w_pop, w_dup;
  logic [AW-1:0] w_wp2;
  logic [4:0]    w_head_rd;
  assign wb_ready  = r_occ <= READY_MAX;
  assign q_full    = r_occ == FULL_OCC;
  assign q_empty   = r_occ == '0;
  assign w_push1   = wb_ready && wb1_valid && wb1_wen && wb1_rd != 5'd0;
  assign w_push2   = wb_ready && wb2_valid && wb2_wen && wb2_rd != 5'd0;
  assign w_pop     = !q_empty;
  assign w_wp2     = r_wp + AW'(w_push1);
  assign w_head_rd = r_rd[r_rp];
  // Suppress the clear while any later write to the same rd is still pending after this edge
  always_comb begin
    w_dup = (w_push1 && wb1_rd == w_head_rd) || (w_push2 && wb2_rd == w_head_rd);
    for (int i = 0; i < QDEPTH; i++)
      if ((AW'(i) - r_rp) != '0 && {1'b0, AW'(i) - r_rp} < r_occ && r_rd[i] == w_head_rd)
        w_dup = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (w_push1) begin
      r_rd[r_wp]   <= wb1_rd;
      r_data[r_wp] <= wb1_data;
    end
    if (w_push2) begin
      r_rd[w_wp2]   <= wb2_rd;
      r_data[w_wp2] <= wb2_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_occ     <= '0;
      r_we      <= 1'b0;
      r_clr     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_clr_idx <= '0;
      r_cnt     <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push1) + AW'(w_push2);
      r_rp  <= r_rp + AW'(w_pop);
      r_occ <= r_occ + (AW+1)'(w_push1) + (AW+1)'(w_push2) - (AW+1)'(w_pop);
      r_we  <= w_pop;
      r_clr <= w_pop && !w_dup;
      if (w_pop) begin
        r_waddr <= w_head_rd;
        r_wdata <= r_data[r_rp];
      end
      if (w_pop && !w_dup) r_clr_idx <= w_head_rd;
      if (wb_ready) r_cnt <= r_cnt + 16'(wb1_valid) + 16'(wb2_valid);
    end
  end
  assign rf_we        = r_we;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign sb_clr       = r_clr;
  assign sb_clr_idx   = r_clr_idx;
  assign retire_count = r_cnt;
endmodule

// File: tb/tb_writeback_retire.sv
// tb_writeback_retire: directed self-checking bench for writeback_retire (QDEPTH=4)
module tb_writeback_retire;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb1_valid, wb1_wen, wb2_valid, wb2_wen;
  logic [4:0]  wb1_rd, wb2_rd;
  logic [31:0] wb1_data, wb2_data;
  logic        wb_ready, rf_we, sb_clr, q_full, q_empty;
  logic [4:0]  rf_waddr, sb_clr_idx;
  logic [31:0] rf_wdata;
  logic [15:0] retire_count;
  int          checks = 0;
  int          errors = 0;
  writeback_retire #(.QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb1_valid(wb1_valid), .wb1_wen(wb1_wen), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .wb2_valid(wb2_valid), .wb2_wen(wb2_wen), .wb2_rd(wb2_rd), .wb2_data(wb2_data),
    .wb_ready(wb_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_clr(sb_clr), .sb_clr_idx(sb_clr_idx), .retire_count(retire_count),
    .q_full(q_full), .q_empty(q_empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic lane1(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
    wb1_valid = v; wb1_wen = w; wb1_rd = rd; wb1_data = d;
  endtask
  task automatic lane2(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
    wb2_valid = v; wb2_wen = w; wb2_rd = rd; wb2_data = d;
  endtask
  initial begin
    int n, wc;
    logic acc, stall;
    lane1(0, 0, 0, 0);
    lane2(0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_waddr_wdata", {rf_waddr, rf_wdata[26:0]}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_sb", {sb_clr, sb_clr_idx}, 0);
    chk("rst_count", 32'(retire_count), 0);
    chk("rst_status", {q_empty, q_full, wb_ready}, 3'b101);
    rst_n = 1'b1;
    lane1(1, 1, 5'd5, 32'hDEADBEEF);
    step();
    lane1(0, 0, 0, 0);
    chk("single_lat", {rf_we, sb_clr, q_empty}, 3'b000);
    chk("single_count", 32'(retire_count), 1);
    step();
    chk("single_we", {rf_we, rf_waddr, sb_clr, sb_clr_idx}, {1'b1, 5'd5, 1'b1, 5'd5});
    chk("single_data", rf_wdata, 32'hDEADBEEF);
    step();
    chk("single_idle", {rf_we, sb_clr, rf_waddr, q_empty}, {1'b0, 1'b0, 5'd5, 1'b1});
    chk("single_hold", rf_wdata, 32'hDEADBEEF);
    lane1(1, 1, 5'd3, 32'd1);
    lane2(1, 1, 5'd3, 32'd2);
    step();
    lane1(0, 0, 0, 0);
    lane2(0, 0, 0, 0);
    chk("dual_count", 32'(retire_count), 3);
    step();
    chk("dual_w1", {rf_we, rf_waddr, sb_clr}, {1'b1, 5'd3, 1'b0});
    chk("dual_d1", rf_wdata, 1);
    step();
    chk("dual_w2", {rf_we, rf_waddr, sb_clr, sb_clr_idx}, {1'b1, 5'd3, 1'b1, 5'd3});
    chk("dual_d2", rf_wdata, 2);
    step();
    chk("dual_idle", {rf_we, sb_clr}, 0);
    lane1(1, 1, 5'd0, 32'h11);
    lane2(1, 0, 5'd7, 32'h22);
    step();
    lane1(0, 0, 0, 0);
    lane2(0, 0, 0, 0);
    chk("nowr_count", 32'(retire_count), 5);
    chk("nowr_empty", {q_empty, rf_we, sb_clr}, 3'b100);
    step();
    chk("nowr_idle", {rf_we, sb_clr, q_empty}, 3'b001);
    n = 0;
    wc = 0;
    stall = 1'b0;
    for (int c = 0; c < 40 && wc < 10; c++) begin
      lane1(n < 10, 1, 5'(n + 1), 32'(100 + n));
      lane2(n < 10, 1, 5'(n + 2), 32'(101 + n));
      acc = wb_ready;
      if (!wb_ready) stall = 1'b1;
      step();
      if (acc && n < 10) n += 2;
      if (rf_we) begin
        chk("bp_order", rf_wdata, 32'(100 + wc));
        wc++;
      end
    end
    lane1(0, 0, 0, 0);
    lane2(0, 0, 0, 0);
    chk("bp_writes", 32'(wc), 10);
    chk("bp_stalled", 32'(stall), 1);
    chk("bp_count", 32'(retire_count), 15);
    chk("bp_empty", 32'(q_empty), 1);
    lane1(1, 1, 5'd9, 32'hA);
    step();
    lane1(1, 1, 5'd9, 32'hB);
    step();
    lane1(0, 0, 0, 0);
    chk("waw_first", {rf_we, rf_waddr, sb_clr}, {1'b1, 5'd9, 1'b0});
    chk("waw_first_d", rf_wdata, 32'hA);
    step();
    chk("waw_last", {rf_we, rf_waddr, sb_clr, sb_clr_idx}, {1'b1, 5'd9, 1'b1, 5'd9});
    chk("waw_last_d", rf_wdata, 32'hB);
    chk("waw_count", 32'(retire_count), 17);
    step();
    lane1(1, 1, 5'd1, 32'h1);
    lane2(1, 1, 5'd2, 32'h2);
    step();
    lane1(1, 1, 5'd3, 32'h3);
    lane2(1, 1, 5'd4, 32'h4);
    step();
    chk("mid_occ3", {wb_ready, q_full, q_empty}, 3'b000);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst", {q_empty, rf_we, sb_clr, wb_ready}, 4'b1001);
    chk("mid_rst_count", 32'(retire_count), 0);
    lane1(0, 0, 0, 0);
    lane2(0, 0, 0, 0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_no_stale", {rf_we, sb_clr, q_empty}, 3'b001);
    end
    lane1(1, 0, 5'd4, 0);
    lane2(1, 0, 5'd6, 0);
    repeat (32767) step();
    lane2(0, 0, 0, 0);
    step();
    chk("wrap_max", 32'(retire_count), 65535);
    lane2(1, 0, 5'd6, 0);
    step();
    lane1(0, 0, 0, 0);
    lane2(0, 0, 0, 0);
    chk("wrap_one", 32'(retire_count), 1);
    chk("wrap_empty", {q_empty, rf_we}, 2'b10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
